parity_serializer: RTL and testbench

- Serial frame transmitter that sequences parity generation over a byte stream.
- Accepts one parallel word per valid/ready handshake and computes its even or odd parity bit through a parity sub-module.
- Shifts out a framed word: start bit, data bits LSB first, parity bit, stop bit.
- Sits between a byte-producing datapath and a single-wire serial link; it is the only scheduler of the parity datapath.

---
 rtl/parity_pkg.sv | 15 +
 rtl/word_parity.sv | 17 +
 rtl/parity_serializer.sv | 133 +++++++++++++
 tb/tb_parity_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity serializer: FSM state encoding and parity modes.
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/word_parity.sv
// Combinational parity of a DATA_W-bit word; even or odd selected by odd_sel.
module word_parity
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd_sel,
  output logic              parity
);

  // XOR reduction gives the even-parity bit; odd mode inverts it
  always_comb begin
    parity = (^data) ^ (odd_sel == PAR_ODD);
  end

endmodule

// File: rtl/parity_serializer.sv
// Framed serial transmitter: start bit, data LSB first, parity bit, stop bit.
module parity_serializer
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              odd_sel,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              parity_out
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              parity_q, parity_d;
  logic              par_calc;
  logic              bit_end;

  // Parity is evaluated on the word being latched so that the registered
  // bit is already valid in the first START cycle.
  word_parity #(
    .DATA_W(DATA_W)
  ) u_word_parity (
    .data   (in_data),
    .odd_sel(odd_sel),
    .parity (par_calc)
  );

  assign in_ready   = (state_q == IDLE);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign parity_out = parity_q;

  // Next-state, counters and shift register; registered outputs are derived
  // from the next state so tx/busy/done line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_end   = (clk_cnt_q == CLK_LAST);

    if (state_q != IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = in_data;
          parity_d  = par_calc;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (clk_cnt_d == CLK_LAST);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      parity_q  <= parity_d;
    end
  end

endmodule

// File: tb/tb_parity_serializer.sv
// Self-checking bench for parity_serializer (default and single-clock-per-bit builds).
module tb_parity_serializer;

  localparam int FRAME4 = 11 * 4;
  localparam int FRAME1 = 11;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, odd_sel, tx, busy, done, parity_out;
  logic [7:0] in_data;
  logic       in_valid1, in_ready1, odd_sel1, tx1, busy1, done1, parity_out1;
  logic [7:0] in_data1;

  int checks = 0;
  int errors = 0;

  parity_serializer #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .odd_sel(odd_sel), .tx(tx), .busy(busy), .done(done),
    .parity_out(parity_out)
  );

  parity_serializer #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .odd_sel(odd_sel1), .tx(tx1), .busy(busy1), .done(done1),
    .parity_out(parity_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference parity: makes the total count of ones even, or odd in odd mode
  function automatic logic ref_parity(input logic [7:0] d, input logic o);
    logic p;
    p = ($countones(d) % 2) != 0;
    return p ^ o;
  endfunction

  // Expected line level in frame cycle k (1-based): bit index = (k-1)/cpb
  function automatic logic ref_tx(input logic [7:0] d, input logic o, input int k, input int cpb);
    int b;
    b = (k - 1) / cpb;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9) return ref_parity(d, o);
    return 1'b1;
  endfunction

  // Sends one frame on the default DUT and checks every cycle of it plus the
  // following idle cycle. pre=1: the word was already accepted by a chained call.
  task automatic xmit(input logic [7:0] d, input logic o, input bit toggle,
                      input bit chain, input logic [7:0] nd, input logic no, input bit pre);
    logic p;
    p = ref_parity(d, o);
    if (!pre) begin
      in_valid = 1'b1;
      in_data  = d;
      odd_sel  = o;
      @(negedge clk);
      check_eq("in_ready_idle", in_ready, 1'b1);
      check_eq("tx_idle", tx, 1'b1);
      @(posedge clk);
      #1;
    end
    if (!toggle && !chain) in_valid = 1'b0;
    for (int k = 1; k <= FRAME4; k++) begin
      if (toggle) begin
        in_data = 8'($urandom);
        odd_sel = 1'($urandom);
      end
      @(negedge clk);
      check_eq($sformatf("tx[%0d] d=%0h", k, d), tx, ref_tx(d, o, k, 4));
      check_eq($sformatf("busy[%0d]", k), busy, 1'b1);
      check_eq($sformatf("in_ready[%0d]", k), in_ready, 1'b0);
      check_eq($sformatf("done[%0d]", k), done, (k == FRAME4));
      if (k == 1 || k == FRAME4) check_eq($sformatf("parity[%0d] d=%0h", k, d), parity_out, p);
      @(posedge clk);
      #1;
    end
    if (chain) begin
      in_data = nd;
      odd_sel = no;
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("tx_gap", tx, 1'b1);
    check_eq("in_ready_gap", in_ready, 1'b1);
    check_eq("busy_gap", busy, 1'b0);
    check_eq("done_gap", done, 1'b0);
    check_eq("parity_hold", parity_out, p);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int saw_done;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    odd_sel   = 1'b0;
    in_valid1 = 1'b0;
    in_data1  = '0;
    odd_sel1  = 1'b0;

    @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_parity", parity_out, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_tx1", tx1, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed words
    xmit(8'hA5, 1'b0, 0, 0, 8'h00, 1'b0, 0);
    xmit(8'h07, 1'b1, 0, 0, 8'h00, 1'b0, 0);
    xmit(8'h07, 1'b0, 0, 0, 8'h00, 1'b0, 0);

    // Back-to-back with in_valid held high: one idle cycle between frames
    xmit(8'h00, 1'b0, 0, 1, 8'hFF, 1'b1, 0);
    xmit(8'hFF, 1'b1, 0, 0, 8'h00, 1'b0, 1);

    // Inputs churning mid-frame must not disturb the latched word
    xmit(8'hC3, 1'b1, 1, 0, 8'h00, 1'b0, 0);

    // Reset during DATA bit 3 aborts the frame
    in_valid = 1'b1;
    in_data  = 8'h96;
    odd_sel  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("pre_rst_tx_bit3", tx, ref_tx(8'h96, 1'b1, 18, 4));
    check_eq("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_tx", tx, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_in_ready", in_ready, 1'b1);
    check_eq("abort_parity", parity_out, 1'b0);
    saw_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (done || busy || !tx) saw_done++;
    end
    check_eq("abort_quiet", saw_done, 0);
    @(posedge clk);
    #1;
    xmit(8'h3C, 1'b0, 0, 0, 8'h00, 1'b0, 0);

    // Randomized frames
    for (int n = 0; n < 12; n++) begin
      xmit(8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), 0, 8'h00, 1'b0, 0);
    end

    // One clock per bit
    in_valid1 = 1'b1;
    in_data1  = 8'h80;
    odd_sel1  = 1'b0;
    @(negedge clk);
    check_eq("c1_in_ready", in_ready1, 1'b1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    for (int k = 1; k <= FRAME1; k++) begin
      @(negedge clk);
      check_eq($sformatf("c1_tx[%0d]", k), tx1, ref_tx(8'h80, 1'b0, k, 1));
      check_eq($sformatf("c1_done[%0d]", k), done1, (k == FRAME1));
      check_eq($sformatf("c1_busy[%0d]", k), busy1, 1'b1);
      if (k == 1) check_eq("c1_parity", parity_out1, ref_parity(8'h80, 1'b0));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_eq("c1_idle_tx", tx1, 1'b1);
    check_eq("c1_idle_ready", in_ready1, 1'b1);
    check_eq("c1_idle_busy", busy1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
